proc_run_ctrl: RTL and testbench
================================

// Module: proc_run_ctrl
// PURPOSE
// Run controller for the Processor core. Sequences the core reset, enables it for a bounded
// cycle budget and monitors NFLAG status flags (flag 0 = ZF). Counts flag events and ends the
// run on abort, a selected flag, or timeout. It replaces the fixed reset-pulse/fixed-runtime
// scheme with a parametrised, synthesisable block sitting between the system reset and the core.
// PARAMETERS
// CNT_W      16         width of cycle_count; MAX_CYCLES <= 2**CNT_W-1
// RST_CYCLES 2          cycles core_reset is held in HOLD (>=1)
// MAX_CYCLES 70         RUN-cycle budget; 0 = no timeout
// NFLAG      1          number of monitored flags
// FCNT_W     8          width of each per-flag rising-edge counter
// STOP_MASK  {NFLAG{0}} flags that end the run when high in RUN
// AUTO_START 1          1: leave IDLE without start; 0: wait for start
// PORTS
// clk         in  1            system clock, rising edge
// reset       in  1            asynchronous, active-high reset
// start       in  1            begin a run from IDLE/DONE (level sampled each edge)
// abort       in  1            end the run (RUN) / cancel a pending one (IDLE, HOLD)
// flags       in  NFLAG        core status flags, synchronous to clk
// core_reset  out 1            registered reset to the core
// core_en     out 1            core clock enable
// busy        out 1            1 in HOLD and RUN
// done        out 1            sticky: run ended
// timeout     out 1            sticky: run ended on budget
// stop_flags  out NFLAG        flags & STOP_MASK captured at a flag stop
// cycle_count out CNT_W        RUN cycles completed
// flag_counts out NFLAG*FCNT_W packed counters, flag i at [i*FCNT_W +: FCNT_W]
// BEHAVIOUR
// - reset=1 (async, immediate, no clock needed): state=IDLE, core_reset=1, core_en=0, busy=0,
//   done=0, timeout=0, stop_flags=0, cycle_count=0, flag_counts=0, flag history=0.
// - All outputs are decoded from registers (no input->output combinational path).
// - IDLE: core_reset=1, core_en=0. Next=HOLD if (AUTO_START | start) & ~abort; else stay.
// - HOLD: core_reset=1, core_en=0, busy=1. Entry clears done, timeout, stop_flags, cycle_count,
//   flag_counts and history. Stays exactly RST_CYCLES cycles, then RUN. abort -> IDLE.
// - RUN: core_reset=0, core_en=1, busy=1. Every edge: cycle_count+1, saturating at all-ones.
//   Rising edges (flags & ~prev) increment flag_counts[i], saturating at 2**FCNT_W-1.
//   prev<=flags. The final RUN cycle still counts cycles and flag edges.
// - RUN exit priority (same edge): abort -> DONE, done=1, timeout=0;
//   else |(flags&STOP_MASK) -> DONE, done=1, stop_flags=flags&STOP_MASK;
//   else MAX_CYCLES!=0 && cycle_count+1==MAX_CYCLES -> DONE, done=1, timeout=1.
// - DONE: core_reset=0, core_en=0 (core frozen for inspection), busy=0; all results hold.
//   start & ~abort -> HOLD. Otherwise stay; AUTO_START does not restart from DONE.
// - start ignored in HOLD/RUN. A flag already high at RUN entry counts as one edge (prev=0).
// - Reset mid-run aborts at once; no result is retained.
// TESTING
// 1 defaults, flags=0, release reset: core_reset=1 for 1 IDLE + 2 HOLD cycles, then 70 RUN
//   cycles -> done=1, timeout=1, cycle_count=70, core_en=0, busy=0.
// 2 STOP_MASK=1: flags[0]=1 while cycle_count==9 -> next edge done=1, timeout=0,
//   stop_flags=1, cycle_count=10, flag_counts=1.
// 3 NFLAG=2, FCNT_W=2, STOP_MASK=0: flags[0] high from RUN entry, flags[1] 5 pulses ->
//   at timeout flag_counts[1:0]=1, flag_counts[3:2]=3 (saturated).
// 4 abort on the edge where cycle_count+1==MAX_CYCLES -> done=1, timeout=0. Then start=1 ->
//   HOLD: done=0, cycle_count=0, core_reset=1 for 2 cycles, RUN again.
// 5 reset asserted between edges mid-RUN (cycle_count=30) -> core_reset=1, core_en=0,
//   cycle_count=0, flag_counts=0 immediately, before the next clk edge.
// 6 AUTO_START=0: start=0 for 20 cycles -> IDLE, core_reset=1; start=abort=1 -> stays IDLE;
//   start alone -> HOLD next edge.

Source files
------------

// File: rtl/proc_run_ctrl.sv
// -----------------------------------------------------------------------------
// proc_run_ctrl
// Run controller for the processor core. Holds the core in reset for a fixed
// number of cycles, then enables it for a bounded cycle budget. While the core
// runs, the block counts rising edges on its status flags. A run ends on abort,
// on a selected stop flag, or when the budget is used up. The results stay
// frozen in DONE until a new start.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_start        begin a run from IDLE/DONE (level, sampled every edge)
//   i_abort        end the run (RUN) / cancel a pending one (IDLE, HOLD)
//   i_flags        core status flags [NFLAG-1:0], synchronous to i_clk
//   o_core_reset   reset to the core (1 in IDLE and HOLD)
//   o_core_en      core clock enable (1 in RUN only)
//   o_busy         1 in HOLD and RUN
//   o_done         sticky: run ended
//   o_timeout      sticky: run ended on the cycle budget
//   o_stop_flags   flags & STOP_MASK captured when a stop flag ended the run
//   o_cycle_count  RUN cycles completed (saturating)
//   o_flag_counts  per-flag rising-edge counters, flag i at [i*FCNT_W +: FCNT_W]
// -----------------------------------------------------------------------------
module proc_run_ctrl #(
   parameter int               CNT_W      = 16,
   parameter int               RST_CYCLES = 2,
   parameter int               MAX_CYCLES = 70,
   parameter int               NFLAG      = 1,
   parameter int               FCNT_W     = 8,
   parameter logic [NFLAG-1:0] STOP_MASK  = '0,
   parameter bit               AUTO_START = 1'b1
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic                    i_abort,
   input  logic [NFLAG-1:0]        i_flags,
   output logic                    o_core_reset,
   output logic                    o_core_en,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_timeout,
   output logic [NFLAG-1:0]        o_stop_flags,
   output logic [CNT_W-1:0]        o_cycle_count,
   output logic [NFLAG*FCNT_W-1:0] o_flag_counts
);

   localparam int               HOLD_W    = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [HOLD_W-1:0]       r_hold_cnt;
   logic [CNT_W-1:0]        r_cycle_count;
   logic [NFLAG*FCNT_W-1:0] r_flag_counts;
   logic [NFLAG-1:0]        r_prev;
   logic                    r_done;
   logic                    r_timeout;
   logic [NFLAG-1:0]        r_stop_flags;

   logic [NFLAG-1:0]        w_rise;
   logic [NFLAG-1:0]        w_stop_sel;
   logic                    w_stop_hit;
   logic                    w_budget_hit;
   logic [CNT_W-1:0]        w_cnt_inc;

   assign w_rise     = i_flags & ~r_prev;
   assign w_stop_sel = i_flags & STOP_MASK;
   assign w_stop_hit = |w_stop_sel;
   assign w_cnt_inc  = r_cycle_count + CNT_W'(1);
   // A budget of 0 disables the timeout. An all-ones count wraps to 0 here, so it never matches.
   assign w_budget_hit = (MAX_CYCLES != 0) && (w_cnt_inc == MAX_C);

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; RUN exit priority is abort, then stop flag, then budget
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if ((AUTO_START | i_start) & ~i_abort) w_state_nxt = S_HOLD;
            else                                   w_state_nxt = S_IDLE;
         end
         S_HOLD: begin
            if (i_abort)                        w_state_nxt = S_IDLE;
            else if (r_hold_cnt == HOLD_LAST)   w_state_nxt = S_RUN;
            else                                w_state_nxt = S_HOLD;
         end
         S_RUN: begin
            if (i_abort || w_stop_hit || w_budget_hit) w_state_nxt = S_DONE;
            else                                       w_state_nxt = S_RUN;
         end
         S_DONE: begin
            if (i_start & ~i_abort) w_state_nxt = S_HOLD;
            else                    w_state_nxt = S_DONE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Hold timer, run counters, flag edge counters and sticky results
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_hold_cnt    <= '0;
         r_cycle_count <= '0;
         r_flag_counts <= '0;
         r_prev        <= '0;
         r_done        <= 1'b0;
         r_timeout     <= 1'b0;
         r_stop_flags  <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               // Entering HOLD starts a fresh run: clear all results and the edge history
               if (w_state_nxt == S_HOLD) begin
                  r_hold_cnt    <= '0;
                  r_cycle_count <= '0;
                  r_flag_counts <= '0;
                  r_prev        <= '0;
                  r_done        <= 1'b0;
                  r_timeout     <= 1'b0;
                  r_stop_flags  <= '0;
               end
            end
            S_HOLD: begin
               r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
            S_RUN: begin
               if (!(&r_cycle_count)) r_cycle_count <= w_cnt_inc;
               for (int i = 0; i < NFLAG; i++) begin
                  if (w_rise[i] && !(&r_flag_counts[i*FCNT_W +: FCNT_W]))
                     r_flag_counts[i*FCNT_W +: FCNT_W] <=
                        r_flag_counts[i*FCNT_W +: FCNT_W] + FCNT_W'(1);
               end
               r_prev <= i_flags;
               if (i_abort) begin
                  r_done    <= 1'b1;
                  r_timeout <= 1'b0;
               end else if (w_stop_hit) begin
                  r_done       <= 1'b1;
                  r_stop_flags <= w_stop_sel;
               end else if (w_budget_hit) begin
                  r_done    <= 1'b1;
                  r_timeout <= 1'b1;
               end
            end
            default: begin
               r_hold_cnt <= '0;
            end
         endcase
      end
   end

   // The outputs decode registers only, so there is no path from the inputs to the outputs
   assign o_core_reset  = (r_state == S_IDLE) || (r_state == S_HOLD);
   assign o_core_en     = (r_state == S_RUN);
   assign o_busy        = (r_state == S_HOLD) || (r_state == S_RUN);
   assign o_done        = r_done;
   assign o_timeout     = r_timeout;
   assign o_stop_flags  = r_stop_flags;
   assign o_cycle_count = r_cycle_count;
   assign o_flag_counts = r_flag_counts;

endmodule

// File: tb/tb_proc_run_ctrl.sv
module tb_proc_run_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // DUT A: default parameters
   logic a_start, a_abort; logic [0:0] a_flags;
   logic a_cr, a_en, a_busy, a_done, a_to; logic [0:0] a_sf;
   logic [15:0] a_cnt; logic [7:0] a_fc;
   proc_run_ctrl dut_a (
      .i_clk(clk), .i_reset(rst), .i_start(a_start), .i_abort(a_abort), .i_flags(a_flags),
      .o_core_reset(a_cr), .o_core_en(a_en), .o_busy(a_busy), .o_done(a_done),
      .o_timeout(a_to), .o_stop_flags(a_sf), .o_cycle_count(a_cnt), .o_flag_counts(a_fc));

   // DUT B: flag 0 stops the run
   logic b_start, b_abort; logic [0:0] b_flags;
   logic b_cr, b_en, b_busy, b_done, b_to; logic [0:0] b_sf;
   logic [15:0] b_cnt; logic [7:0] b_fc;
   proc_run_ctrl #(.STOP_MASK(1'b1)) dut_b (
      .i_clk(clk), .i_reset(rst), .i_start(b_start), .i_abort(b_abort), .i_flags(b_flags),
      .o_core_reset(b_cr), .o_core_en(b_en), .o_busy(b_busy), .o_done(b_done),
      .o_timeout(b_to), .o_stop_flags(b_sf), .o_cycle_count(b_cnt), .o_flag_counts(b_fc));

   // DUT C: two flags, 2-bit counters
   logic c_start, c_abort; logic [1:0] c_flags;
   logic c_cr, c_en, c_busy, c_done, c_to; logic [1:0] c_sf;
   logic [15:0] c_cnt; logic [3:0] c_fc;
   proc_run_ctrl #(.NFLAG(2), .FCNT_W(2), .STOP_MASK(2'b00)) dut_c (
      .i_clk(clk), .i_reset(rst), .i_start(c_start), .i_abort(c_abort), .i_flags(c_flags),
      .o_core_reset(c_cr), .o_core_en(c_en), .o_busy(c_busy), .o_done(c_done),
      .o_timeout(c_to), .o_stop_flags(c_sf), .o_cycle_count(c_cnt), .o_flag_counts(c_fc));

   // DUT D: waits for start
   logic d_start, d_abort; logic [0:0] d_flags;
   logic d_cr, d_en, d_busy, d_done, d_to; logic [0:0] d_sf;
   logic [15:0] d_cnt; logic [7:0] d_fc;
   proc_run_ctrl #(.AUTO_START(1'b0)) dut_d (
      .i_clk(clk), .i_reset(rst), .i_start(d_start), .i_abort(d_abort), .i_flags(d_flags),
      .o_core_reset(d_cr), .o_core_en(d_en), .o_busy(d_busy), .o_done(d_done),
      .o_timeout(d_to), .o_stop_flags(d_sf), .o_cycle_count(d_cnt), .o_flag_counts(d_fc));

   typedef struct {
      logic       s, a, f;
      int         n;
      logic       cr, en, busy, done, to;
      logic [15:0] cnt;
      logic [7:0]  fc;
   } vec_t;

   localparam int NV = 25;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a_start = 0; a_abort = 0; a_flags = 0;
      b_start = 0; b_abort = 0; b_flags = 0;
      c_start = 0; c_abort = 0; c_flags = 0;
      d_start = 0; d_abort = 0; d_flags = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      //          s  a  f   n   cr en bs dn to  cnt  fc
      tbl[0]  = '{0, 0, 0,  0,  1, 0, 0, 0, 0,  0,   0};  // IDLE after reset
      tbl[1]  = '{0, 0, 0,  1,  1, 0, 1, 0, 0,  0,   0};  // HOLD 1
      tbl[2]  = '{0, 0, 0,  1,  1, 0, 1, 0, 0,  0,   0};  // HOLD 2
      tbl[3]  = '{0, 0, 0,  1,  0, 1, 1, 0, 0,  0,   0};  // RUN entry
      tbl[4]  = '{0, 0, 0,  1,  0, 1, 1, 0, 0,  1,   0};
      tbl[5]  = '{0, 0, 0, 68,  0, 1, 1, 0, 0, 69,   0};
      tbl[6]  = '{0, 0, 0,  1,  0, 0, 0, 1, 1, 70,   0};  // timeout
      tbl[7]  = '{0, 0, 0,  5,  0, 0, 0, 1, 1, 70,   0};  // DONE holds, no auto restart
      tbl[8]  = '{1, 0, 0,  1,  1, 0, 1, 0, 0,  0,   0};  // restart clears results
      tbl[9]  = '{0, 0, 0,  1,  1, 0, 1, 0, 0,  0,   0};
      tbl[10] = '{0, 0, 0,  1,  0, 1, 1, 0, 0,  0,   0};
      tbl[11] = '{0, 0, 1,  1,  0, 1, 1, 0, 0,  1,   1};  // rising edge
      tbl[12] = '{0, 0, 1,  3,  0, 1, 1, 0, 0,  4,   1};  // level, no new edge
      tbl[13] = '{0, 0, 0,  1,  0, 1, 1, 0, 0,  5,   1};
      tbl[14] = '{0, 0, 1,  1,  0, 1, 1, 0, 0,  6,   2};
      tbl[15] = '{0, 0, 0, 62,  0, 1, 1, 0, 0, 68,   2};
      tbl[16] = '{0, 0, 0,  1,  0, 1, 1, 0, 0, 69,   2};
      tbl[17] = '{0, 1, 0,  1,  0, 0, 0, 1, 0, 70,   2};  // abort on budget edge
      tbl[18] = '{0, 0, 0,  3,  0, 0, 0, 1, 0, 70,   2};
      tbl[19] = '{1, 0, 0,  1,  1, 0, 1, 0, 0,  0,   0};  // HOLD again
      tbl[20] = '{0, 1, 0,  1,  1, 0, 0, 0, 0,  0,   0};  // abort in HOLD -> IDLE
      tbl[21] = '{0, 0, 0,  1,  1, 0, 1, 0, 0,  0,   0};  // auto start
      tbl[22] = '{0, 0, 0,  2,  0, 1, 1, 0, 0,  0,   0};
      tbl[23] = '{1, 0, 0,  1,  0, 1, 1, 0, 0,  1,   0};  // start ignored in RUN
      tbl[24] = '{0, 0, 0,  1,  0, 1, 1, 0, 0,  2,   0};

      // ---- table-driven sequence on DUT A ----
      do_reset();
      chk("rst_sf", 32'(a_sf), 32'd0);
      for (int i = 0; i < NV; i++) begin
         a_start = tbl[i].s; a_abort = tbl[i].a; a_flags = tbl[i].f;
         step(tbl[i].n);
         chk($sformatf("row%0d_core_reset", i), 32'(a_cr),   32'(tbl[i].cr));
         chk($sformatf("row%0d_core_en", i),    32'(a_en),   32'(tbl[i].en));
         chk($sformatf("row%0d_busy", i),       32'(a_busy), 32'(tbl[i].busy));
         chk($sformatf("row%0d_done", i),       32'(a_done), 32'(tbl[i].done));
         chk($sformatf("row%0d_timeout", i),    32'(a_to),   32'(tbl[i].to));
         chk($sformatf("row%0d_cycle_count", i),32'(a_cnt),  32'(tbl[i].cnt));
         chk($sformatf("row%0d_flag_counts", i),32'(a_fc),   32'(tbl[i].fc));
      end

      // ---- stop flag on DUT B ----
      do_reset();
      step(3);
      step(9);
      chk("stop_pre_cnt", 32'(b_cnt), 32'd9);
      chk("stop_pre_en", 32'(b_en), 32'd1);
      b_flags = 1'b1;
      step(1);
      chk("stop_done", 32'(b_done), 32'd1);
      chk("stop_timeout", 32'(b_to), 32'd0);
      chk("stop_flags", 32'(b_sf), 32'd1);
      chk("stop_cnt", 32'(b_cnt), 32'd10);
      chk("stop_fc", 32'(b_fc), 32'd1);
      chk("stop_en", 32'(b_en), 32'd0);
      b_flags = 1'b0;
      step(2);
      chk("stop_flags_hold", 32'(b_sf), 32'd1);
      chk("stop_done_hold", 32'(b_done), 32'd1);

      // ---- flag counter saturation on DUT C ----
      do_reset();
      c_flags = 2'b01;
      step(3);
      for (int p = 0; p < 5; p++) begin
         c_flags[1] = 1'b1; step(1);
         c_flags[1] = 1'b0; step(1);
      end
      begin
         int k;
         k = 0;
         while (!c_done && k < 200) begin
            step(1);
            k++;
         end
         if (!c_done) begin
            total++; bad++;
            $display("FAIL sat_wait_done: got done=0 expected done=1 within 200 cycles");
         end
      end
      chk("sat_timeout", 32'(c_to), 32'd1);
      chk("sat_cnt", 32'(c_cnt), 32'd70);
      chk("sat_fc", 32'(c_fc), 32'hD);
      chk("sat_sf", 32'(c_sf), 32'd0);

      // ---- async reset mid-run on DUT A ----
      do_reset();
      step(3);
      a_flags = 1'b1; step(1);
      a_flags = 1'b0; step(29);
      chk("mid_cnt", 32'(a_cnt), 32'd30);
      chk("mid_fc", 32'(a_fc), 32'd1);
      #3 rst = 1'b1;
      #1;
      chk("arst_core_reset", 32'(a_cr), 32'd1);
      chk("arst_core_en", 32'(a_en), 32'd0);
      chk("arst_busy", 32'(a_busy), 32'd0);
      chk("arst_cnt", 32'(a_cnt), 32'd0);
      chk("arst_fc", 32'(a_fc), 32'd0);

      // ---- manual start on DUT D ----
      do_reset();
      step(20);
      chk("man_idle_cr", 32'(d_cr), 32'd1);
      chk("man_idle_busy", 32'(d_busy), 32'd0);
      d_start = 1'b1; d_abort = 1'b1;
      step(1);
      chk("man_abort_busy", 32'(d_busy), 32'd0);
      chk("man_abort_cr", 32'(d_cr), 32'd1);
      d_abort = 1'b0;
      step(1);
      chk("man_hold_busy", 32'(d_busy), 32'd1);
      chk("man_hold_cr", 32'(d_cr), 32'd1);
      chk("man_hold_en", 32'(d_en), 32'd0);
      d_start = 1'b0;
      step(2);
      chk("man_run_en", 32'(d_en), 32'd1);
      chk("man_run_cr", 32'(d_cr), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
